// File: rtl/despachador_destinos_pkg.sv
// -----------------------------------------------------------------------------
// despachador_destinos_pkg
// Shared constants for the elevator destination dispatcher:
//   - floor codes (two-bit encoding of floors -1, 1, 2, 3)
//   - the "no destination" code driven on destino
//   - dispatcher FSM state encodings
// -----------------------------------------------------------------------------
package despachador_destinos_pkg;

   localparam logic [1:0] MENOS_UNO = 2'b00;
   localparam logic [1:0] UNO       = 2'b01;
   localparam logic [1:0] DOS       = 2'b10;
   localparam logic [1:0] TRES      = 2'b11;

   // MSB set means "no destination"; MSB clear means floor code in the LSBs.
   localparam logic [2:0] DESTINO_NADA = 3'b100;

   typedef enum logic [1:0] {
      ESPERA   = 2'b00,
      ASIGNADO = 2'b01,
      VIAJANDO = 2'b10
   } estado_t;

endpackage

// File: rtl/cola_destinos.sv
// -----------------------------------------------------------------------------
// cola_destinos
// Small request FIFO holding floor codes waiting to be dispatched.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   push, dato_in   : write request and data (ignored while llena)
//   pop             : read request (ignored while vacia)
//   dato_out        : current head entry (valid while vacia = 0)
//   vacia, llena    : FIFO empty / full flags
// Push and pop in the same cycle both take effect and leave the count unchanged.
// -----------------------------------------------------------------------------
module cola_destinos #(
   parameter int PROFUNDIDAD  = 4,
   parameter int ANCHO        = 2,
   parameter int ANCHO_CUENTA = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [ANCHO-1:0] dato_in,
   input  logic             pop,
   output logic [ANCHO-1:0] dato_out,
   output logic             vacia,
   output logic             llena
);

   localparam int ANCHO_PTR = (PROFUNDIDAD > 1) ? $clog2(PROFUNDIDAD) : 1;

   logic [ANCHO-1:0]        mem [PROFUNDIDAD];
   logic [ANCHO_PTR-1:0]    wr_ptr_q, wr_ptr_d;
   logic [ANCHO_PTR-1:0]    rd_ptr_q, rd_ptr_d;
   logic [ANCHO_CUENTA-1:0] cuenta_q, cuenta_d;
   logic                    push_ok, pop_ok;

   // Pointers wrap explicitly so depths that are not a power of two still work.
   function automatic logic [ANCHO_PTR-1:0] siguiente(input logic [ANCHO_PTR-1:0] p);
      if (p == ANCHO_PTR'(PROFUNDIDAD - 1)) begin
         return '0;
      end
      return p + ANCHO_PTR'(1);
   endfunction

   assign vacia    = (cuenta_q == '0);
   assign llena    = (int'(cuenta_q) == PROFUNDIDAD);
   assign push_ok  = push & ~llena;
   assign pop_ok   = pop & ~vacia;
   assign dato_out = mem[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cuenta_d = cuenta_q;
      if (push_ok) begin
         wr_ptr_d = siguiente(wr_ptr_q);
      end
      if (pop_ok) begin
         rd_ptr_d = siguiente(rd_ptr_q);
      end
      case ({push_ok, pop_ok})
         2'b10:   cuenta_d = cuenta_q + ANCHO_CUENTA'(1);
         2'b01:   cuenta_d = cuenta_q - ANCHO_CUENTA'(1);
         default: cuenta_d = cuenta_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cuenta_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cuenta_q <= cuenta_d;
      end
   end

   // Storage carries no reset; only pointers and count define validity.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr_q] <= dato_in;
      end
   end

endmodule

// File: rtl/despachador_destinos.sv
// -----------------------------------------------------------------------------
// despachador_destinos
// Collects elevator call buttons, queues accepted calls in arrival order and
// issues them one at a time to the elevator.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   boton       : call buttons (level), one bit per floor code
//   piso        : current elevator floor code
//   ocupado     : elevator busy (travelling or doors dwelling)
//   destino     : issued destination, MSB set = none, else {0, floor code}
//   pendientes  : call lamps, set while a floor's call is unserved
//   cola_vacia  : request FIFO empty
//   cola_llena  : request FIFO full
// -----------------------------------------------------------------------------
module despachador_destinos
   import despachador_destinos_pkg::*;
#(
   parameter int PROFUNDIDAD = 4,
   parameter int ANCHO_PISO  = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [2**ANCHO_PISO-1:0]   boton,
   input  logic [ANCHO_PISO-1:0]      piso,
   input  logic                       ocupado,
   output logic [ANCHO_PISO:0]        destino,
   output logic [2**ANCHO_PISO-1:0]   pendientes,
   output logic                       cola_vacia,
   output logic                       cola_llena
);

   localparam int N = 2**ANCHO_PISO;
   localparam logic [ANCHO_PISO:0] NADA = {1'b1, {ANCHO_PISO{1'b0}}};

   logic [N-1:0]          boton_q;
   logic [N-1:0]          pendientes_q, pendientes_d;
   logic [N-1:0]          por_encolar_q, por_encolar_d;
   logic [N-1:0]          flanco, aceptada, sel_bajo;
   estado_t               estado_q, estado_d;
   logic [ANCHO_PISO:0]   destino_q, destino_d;
   logic [ANCHO_PISO-1:0] dato_push, cabeza;
   logic                  push, pop, vacia, llena, servir;
   logic                  reposo;

   // Elevator parked and idle: a call for the floor it is standing on is moot.
   assign reposo = (estado_q == ESPERA) && !ocupado;

   for (genvar gi = 0; gi < N; gi++) begin : g_boton
      assign flanco[gi]   = boton[gi] & ~boton_q[gi];
      assign aceptada[gi] = flanco[gi] & ~pendientes_q[gi]
                            & ~(reposo && (piso == ANCHO_PISO'(gi)));
   end

   // Isolate the lowest pending-to-enqueue bit (two's complement trick).
   assign sel_bajo = por_encolar_q & (~por_encolar_q + N'(1));

   always_comb begin
      dato_push = '0;
      for (int i = 0; i < N; i++) begin
         if (sel_bajo[i]) begin
            dato_push = ANCHO_PISO'(i);
         end
      end
   end

   assign push = (|por_encolar_q) && !llena;
   assign pop  = (estado_q == ESPERA) && !vacia && !ocupado;

   cola_destinos #(
      .PROFUNDIDAD  (PROFUNDIDAD),
      .ANCHO        (ANCHO_PISO),
      .ANCHO_CUENTA (ANCHO_PISO + 1)
   ) u_cola (
      .clk      (clk),
      .rst      (rst),
      .push     (push),
      .dato_in  (dato_push),
      .pop      (pop),
      .dato_out (cabeza),
      .vacia    (vacia),
      .llena    (llena)
   );

   always_comb begin
      estado_d      = estado_q;
      destino_d     = destino_q;
      servir        = 1'b0;
      pendientes_d  = pendientes_q | aceptada;
      por_encolar_d = por_encolar_q | aceptada;
      if (push) begin
         por_encolar_d = por_encolar_d & ~sel_bajo;
      end

      case (estado_q)
         ESPERA: begin
            if (pop) begin
               destino_d = {1'b0, cabeza};
               estado_d  = ASIGNADO;
            end
         end
         ASIGNADO: begin
            if (ocupado) begin
               estado_d = VIAJANDO;
            end else if (piso == destino_q[ANCHO_PISO-1:0]) begin
               // Already at the requested floor: served without moving.
               servir = 1'b1;
            end
         end
         VIAJANDO: begin
            if (!ocupado) begin
               servir = 1'b1;
            end
         end
         default: estado_d = ESPERA;
      endcase

      if (servir) begin
         pendientes_d[destino_q[ANCHO_PISO-1:0]] = 1'b0;
         destino_d = NADA;
         estado_d  = ESPERA;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         // Copy the live buttons so one held through reset is not a press.
         boton_q       <= boton;
         pendientes_q  <= '0;
         por_encolar_q <= '0;
         estado_q      <= ESPERA;
         destino_q     <= NADA;
      end else begin
         boton_q       <= boton;
         pendientes_q  <= pendientes_d;
         por_encolar_q <= por_encolar_d;
         estado_q      <= estado_d;
         destino_q     <= destino_d;
      end
   end

   assign destino    = destino_q;
   assign pendientes = pendientes_q;
   assign cola_vacia = vacia;
   assign cola_llena = llena;

endmodule

// File: tb/tb_despachador_destinos.sv
// -----------------------------------------------------------------------------
// tb_despachador_destinos
// Directed stimulus for despachador_destinos. Expected dispatch order is pushed
// to a scoreboard queue when calls are made and compared whenever a new
// destination appears on destino.
// -----------------------------------------------------------------------------
module tb_despachador_destinos;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] boton;
   logic [1:0] piso;
   logic       ocupado;
   logic [2:0] destino;
   logic [3:0] pendientes;
   logic       cola_vacia;
   logic       cola_llena;

   int vectores = 0;
   int errores  = 0;

   logic [2:0] sb[$];
   logic [2:0] destino_prev;

   always #5 clk = ~clk;

   despachador_destinos #(
      .PROFUNDIDAD (4),
      .ANCHO_PISO  (2)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .boton      (boton),
      .piso       (piso),
      .ocupado    (ocupado),
      .destino    (destino),
      .pendientes (pendientes),
      .cola_vacia (cola_vacia),
      .cola_llena (cola_llena)
   );

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      vectores++;
      assert (obs === exp) else begin
         errores++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
      $display("vector %0d %s: observed %0h expected %0h", vectores, tag, obs, exp);
   endtask

   task automatic ciclo();
      @(posedge clk);
      #1;
   endtask

   task automatic ciclos(input int n);
      for (int i = 0; i < n; i++) ciclo();
   endtask

   // Bounded wait for a destination to be issued.
   task automatic esperar_destino(input string tag);
      int n;
      n = 0;
      while (destino === 3'b100 && n < 20) begin
         ciclo();
         n++;
      end
      check(tag, 8'(destino !== 3'b100), 8'd1);
   endtask

   // Dispatch one queued call, let the elevator travel, then check lamps.
   task automatic servir_uno(input string tag, input logic [3:0] pend_exp);
      ocupado = 1'b0;
      esperar_destino({tag, "_emitido"});
      ocupado = 1'b1;
      ciclo();
      ocupado = 1'b0;
      ciclo();
      check({tag, "_destino"}, 8'(destino), 8'h4);
      check({tag, "_pend"}, 8'(pendientes), 8'(pend_exp));
   endtask

   // Scoreboard: each newly issued destination must be the oldest expected one.
   always @(negedge clk) begin
      if (rst) begin
         destino_prev = 3'b100;
      end else begin
         if (destino !== destino_prev && destino !== 3'b100) begin
            if (sb.size() == 0) begin
               vectores++;
               errores++;
               $error("FAIL despacho_inesperado: observed %0h expected none", destino);
            end else begin
               check("orden_despacho", 8'(destino), 8'(sb.pop_front()));
            end
         end
         destino_prev = destino;
      end
   end

   initial begin
      logic [3:0] pend_exp;
      logic [1:0] codigos [3];

      rst     = 1'b1;
      boton   = 4'b0000;
      piso    = 2'b11;
      ocupado = 1'b0;
      ciclos(2);
      rst = 1'b0;
      check("reset_destino", 8'(destino), 8'h4);
      check("reset_pend", 8'(pendientes), 8'h0);
      check("reset_vacia", 8'(cola_vacia), 8'h1);
      check("reset_llena", 8'(cola_llena), 8'h0);

      // Single call to floor 1 while parked at floor 3.
      boton = 4'b0010;
      sb.push_back(3'b001);
      ciclo();
      check("simple_pend", 8'(pendientes), 8'h2);
      boton = 4'b0000;
      ciclos(2);
      check("simple_destino", 8'(destino), 8'h1);
      ocupado = 1'b1;
      ciclo();
      ocupado = 1'b0;
      ciclo();
      check("simple_servido_destino", 8'(destino), 8'h4);
      check("simple_servido_pend", 8'(pendientes), 8'h0);

      // Three simultaneous calls while busy: served lowest code first.
      piso    = 2'b10;
      ocupado = 1'b1;
      boton   = 4'b1011;
      sb.push_back(3'b000);
      sb.push_back(3'b001);
      sb.push_back(3'b011);
      ciclo();
      check("multi_pend", 8'(pendientes), 8'hB);
      boton = 4'b0000;
      ciclos(3);
      check("multi_vacia", 8'(cola_vacia), 8'h0);
      check("multi_llena", 8'(cola_llena), 8'h0);
      pend_exp = 4'b1011;
      codigos  = '{2'b00, 2'b01, 2'b11};
      for (int k = 0; k < 3; k++) begin
         pend_exp[codigos[k]] = 1'b0;
         servir_uno("multi", pend_exp);
      end

      // Duplicate press while pending yields a single FIFO entry.
      piso    = 2'b00;
      ocupado = 1'b1;
      boton   = 4'b0100;
      sb.push_back(3'b010);
      ciclo();
      boton = 4'b0000;
      ciclo();
      boton = 4'b0100;
      ciclo();
      boton = 4'b0000;
      ciclos(2);
      check("dup_pend", 8'(pendientes), 8'h4);
      ocupado = 1'b0;
      esperar_destino("dup_emitido");
      check("dup_destino", 8'(destino), 8'h2);
      check("dup_una_entrada", 8'(cola_vacia), 8'h1);
      // Elevator reaches floor 2 without ever going busy.
      piso = 2'b10;
      ciclo();
      check("llegada_destino", 8'(destino), 8'h4);
      check("llegada_pend", 8'(pendientes), 8'h0);

      // Call for the floor where the idle elevator stands is ignored.
      piso  = 2'b11;
      boton = 4'b1000;
      ciclo();
      boton = 4'b0000;
      ciclos(3);
      check("mismo_piso_pend", 8'(pendientes), 8'h0);
      check("mismo_piso_vacia", 8'(cola_vacia), 8'h1);
      check("mismo_piso_destino", 8'(destino), 8'h4);

      // Fill the FIFO with all four floors.
      ocupado = 1'b1;
      boton   = 4'b1111;
      sb.push_back(3'b000);
      sb.push_back(3'b001);
      sb.push_back(3'b010);
      sb.push_back(3'b011);
      ciclo();
      boton = 4'b0000;
      ciclos(4);
      check("lleno_llena", 8'(cola_llena), 8'h1);
      check("lleno_pend", 8'(pendientes), 8'hF);
      pend_exp = 4'b1111;
      for (int k = 0; k < 4; k++) begin
         pend_exp[k] = 1'b0;
         servir_uno("lleno", pend_exp);
      end
      check("lleno_drenado", 8'(cola_vacia), 8'h1);

      // Reset in the middle of a trip with two entries still queued.
      piso    = 2'b00;
      ocupado = 1'b1;
      boton   = 4'b1110;
      sb.push_back(3'b001);
      ciclo();
      boton = 4'b0000;
      ciclos(3);
      ocupado = 1'b0;
      esperar_destino("rst_emitido");
      ocupado = 1'b1;
      ciclo();
      check("rst_pre_vacia", 8'(cola_vacia), 8'h0);
      boton = 4'b0001;
      rst   = 1'b1;
      ciclo();
      rst = 1'b0;
      check("rst_destino", 8'(destino), 8'h4);
      check("rst_pend", 8'(pendientes), 8'h0);
      check("rst_vacia", 8'(cola_vacia), 8'h1);
      check("rst_llena", 8'(cola_llena), 8'h0);
      ciclos(3);
      check("rst_boton_pend", 8'(pendientes), 8'h0);
      check("rst_boton_vacia", 8'(cola_vacia), 8'h1);
      boton   = 4'b0000;
      ocupado = 1'b0;
      ciclos(3);
      check("rst_sin_despacho", 8'(destino), 8'h4);

      // Push and pop in the same cycle keep one entry and the order.
      piso    = 2'b00;
      ocupado = 1'b1;
      boton   = 4'b0010;
      sb.push_back(3'b001);
      sb.push_back(3'b010);
      ciclo();
      boton = 4'b0000;
      ciclo();
      boton = 4'b0100;
      ciclo();
      boton   = 4'b0000;
      ocupado = 1'b0;
      ciclo();
      check("pushpop_destino", 8'(destino), 8'h1);
      check("pushpop_vacia", 8'(cola_vacia), 8'h0);
      check("pushpop_llena", 8'(cola_llena), 8'h0);
      ocupado = 1'b1;
      ciclo();
      ocupado = 1'b0;
      ciclo();
      check("pushpop_pend", 8'(pendientes), 8'h4);
      ciclo();
      check("pushpop_segundo", 8'(destino), 8'h2);
      check("pushpop_vacia_fin", 8'(cola_vacia), 8'h1);
      piso = 2'b10;
      ciclo();
      check("pushpop_servido", 8'(pendientes), 8'h0);

      ciclos(2);
      check("scoreboard_consumido", 8'(sb.size()), 8'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectores, errores);
      $finish;
   end

endmodule

// File: doc/despachador_destinos.md
DESPACHADOR_DESTINOS -- requirements
Module: despachador_destinos

Interface
REQ-001 Parameter PROFUNDIDAD, default 4, SHALL set the request FIFO depth in entries; minimum 4.
REQ-002 Parameter ANCHO_PISO, default 2, SHALL set the floor code width.
REQ-003 clk  in  1  SHALL be the single system clock; all logic on its rising edge.
REQ-004 rst  in  1  SHALL be the synchronous, active-high reset.
REQ-005 boton  in  4  SHALL be the call buttons, level, one bit per floor code: bit0 = -1, bit1 = 1, bit2 = 2, bit3 = 3.
REQ-006 piso  in  2  SHALL be the elevator's current floor code.
REQ-007 ocupado  in  1  SHALL be the elevator busy flag: 1 = travelling or doors dwelling.
REQ-008 destino  out  3  SHALL be the destination issued to the elevator: 3'b100 = none; 3'b0xx = floor code xx.
REQ-009 pendientes  out  4  SHALL be the call-lamp bitmap; a bit is set while that floor's request is not yet served.
REQ-010 cola_vacia  out  1  SHALL be high when the FIFO holds 0 entries.
REQ-011 cola_llena  out  1  SHALL be high when the FIFO holds PROFUNDIDAD entries.

Function
REQ-012 The block SHALL register boton once; a press is boton[i] = 1 with the registered copy = 0 (rising edge).
REQ-013 A press on floor i SHALL be ignored if pendientes[i] = 1.
REQ-014 A press on floor i SHALL be ignored if piso = i and ocupado = 0 and the FSM is in ESPERA.
REQ-015 An accepted press SHALL set pendientes[i] and por_encolar[i] at the same clock edge.
REQ-016 Each cycle, the lowest set bit of por_encolar SHALL be pushed into the FIFO and cleared; at most one push per cycle.
REQ-017 A simultaneous push and pop SHALL both occur; count is unchanged.
REQ-018 With cola_llena = 1, no push SHALL occur and por_encolar SHALL be held; no request is lost.
REQ-019 The FSM SHALL have three states: ESPERA, ASIGNADO and VIAJANDO.
REQ-020 ESPERA: destino = 3'b100. If the FIFO is non-empty and ocupado = 0, the FSM SHALL pop the head, load destino = {1'b0, head} and go to ASIGNADO; destino is valid the next cycle.
REQ-021 ASIGNADO: if ocupado = 1, the FSM SHALL go to VIAJANDO. Otherwise, if piso = destino[1:0], it SHALL treat the request as served (REQ-023).
REQ-022 VIAJANDO: destino SHALL be held stable. When ocupado falls to 0, the request SHALL be served (REQ-023).
REQ-023 Serving a request SHALL clear pendientes[destino[1:0]], set destino = 3'b100 and return to ESPERA, all at one edge.
REQ-024 A press for the floor currently being served SHALL be ignored until the pendientes bit clears.
REQ-025 The count register SHALL be ANCHO_PISO+1 bits; the read and write pointers SHALL wrap modulo PROFUNDIDAD.

Reset
REQ-026 When rst = 1 at a clock edge, the block SHALL return to its reset values, including in the middle of an operation:
- destino = 3'b100;
- pendientes = 0;
- por_encolar = 0;
- FIFO count and pointers = 0, so cola_vacia = 1 and cola_llena = 0;
- FSM = ESPERA;
- registered boton copy = current boton, so held buttons do not register a press.

Structure
REQ-027 A shared package SHALL hold the floor codes (MENOS_UNO = 00, UNO = 01, DOS = 10, TRES = 11), DESTINO_NADA = 3'b100 and the FSM state encodings.
REQ-028 The FIFO SHALL be the sub-module cola_destinos (parameterised depth and width, push/pop, vacia/llena flags); the dispatcher FSM and edge logic stay in the top level.

Verification
REQ-029 Single call: piso = 11, ocupado = 0, pulse boton[1].
- pendientes = 0010 one cycle after the press; destino = 3'b001 two cycles after the push.
- Drive ocupado 1 then 0: destino = 3'b100 and pendientes = 0000.
REQ-030 Simultaneous calls: boton = 1011 in one cycle, elevator busy.
- FIFO order SHALL be 00, 01, 11.
- Served in that order; pendientes decrements bit by bit.
REQ-031 Duplicate and same-floor calls:
- Press 10 twice while pending: one FIFO entry only.
- Press 11 while piso = 11, idle: ignored; pendientes stays 0000.
REQ-032 Arrival without busy: destino = 3'b010 issued, piso driven to 10 with ocupado held 0 → served in ASIGNADO, destino = 3'b100.
REQ-033 Reset mid-trip: in VIAJANDO with 2 entries queued, assert rst one cycle.
- destino = 3'b100, pendientes = 0000, cola_vacia = 1.
- A button held through reset does not enqueue.
REQ-034 Push/pop same cycle: FIFO with 1 entry, a new press and a dispatch coincide → count stays 1 and the order is preserved.
